sys_config_master: RTL and testbench

Initiator side of the configuration/CSR bus served by `sys_config`. On a `start` pulse it verifies the link, clears any stale end-of-config flag, writes the read address, write address and I/O length, fires end-of-config, polls the state CSR until the task completes, and then reads the cycle-count CSR. It sits between the host-side control logic (or testbench) and the accelerator's config port. Exactly one job is in flight at a time.

---
 rtl/sys_config_pkg.sv | 20 ++
 rtl/sys_config_master_if.sv | 24 ++
 rtl/sys_config_master.sv | 197 +++++++++++++++++++
 tb/tb_sys_config_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_config_pkg.sv
// Shared definitions for the configuration/CSR bus: CSR addresses, link check word
// and CSR_STATE bit positions, used by both the initiator and the sys_config slave.
package sys_config_pkg;

  localparam int CSR_AW = 6;

  localparam logic [CSR_AW-1:0] CSR_RD_ADDR          = 6'h00;
  localparam logic [CSR_AW-1:0] CSR_WR_ADDR          = 6'h01;
  localparam logic [CSR_AW-1:0] CSR_IO_LEN           = 6'h02;
  localparam logic [CSR_AW-1:0] CSR_END_OF_IN_CONFIG = 6'h20;
  localparam logic [CSR_AW-1:0] CSR_STATE            = 6'h21;
  localparam logic [CSR_AW-1:0] CSR_TIME             = 6'h22;
  localparam logic [CSR_AW-1:0] CSR_CHECK            = 6'h3F;

  localparam logic [31:0] CHECK_WORD = 32'hF0F0_F0F0;

  localparam int STATE_TASK_DONE_BIT   = 0;
  localparam int STATE_UNDER_PROC_BIT  = 1;

endpackage

// File: rtl/sys_config_master_if.sv
// Config/CSR bus between the initiator (master) and the accelerator config port (slave).
interface sys_config_master_if #(
  parameter int CW = 6,
  parameter int DW = 32
);
  logic          config_ena;
  logic [CW-1:0] config_addr;
  logic [DW-1:0] config_wdata;
  logic [DW-1:0] config_rdata;

  modport master (
    output config_ena,
    output config_addr,
    output config_wdata,
    input  config_rdata
  );

  modport slave (
    input  config_ena,
    input  config_addr,
    input  config_wdata,
    output config_rdata
  );
endinterface

// File: rtl/sys_config_master.sv
// Config-bus initiator: checks the link, programs addresses/length, fires end-of-config,
// polls for task completion with a timeout, then reads back the cycle-count CSR.
module sys_config_master
  import sys_config_pkg::*;
#(
  parameter int            AW         = 12,
  parameter int            DW         = 32,
  parameter int            CW         = 6,
  parameter int            TW         = 24,
  parameter logic [TW-1:0] POLL_LIMIT = 24'hFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DW-1:0]        cfg_raddr,
  input  logic [DW-1:0]        cfg_waddr,
  input  logic [AW-1:0]        cfg_iolen,
  sys_config_master_if.master  cfg_bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err,
  output logic [DW-1:0]        time_cost
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHK_A,
    S_CHK_S,
    S_W_CLR,
    S_W_RADDR,
    S_W_WADDR,
    S_W_IOLEN,
    S_W_END,
    S_POLL_A,
    S_POLL_S,
    S_TIME_A,
    S_TIME_S,
    S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [DW-1:0]   r_raddr;
  logic [DW-1:0]   r_waddr;
  logic [AW-1:0]   r_iolen;
  logic [TW-1:0]   r_poll_cnt;
  logic [1:0]      r_err;
  logic [DW-1:0]   r_time_cost;

  logic            w_ena;
  logic [CW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic            w_busy;
  logic            w_done;
  logic            w_check_ok;
  logic            w_task_done;
  logic            w_poll_expired;

  assign w_check_ok     = (cfg_bus.config_rdata == DW'(CHECK_WORD));
  assign w_task_done    = cfg_bus.config_rdata[STATE_TASK_DONE_BIT];
  assign w_poll_expired = (r_poll_cnt == POLL_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus outputs decode straight from the state so each write is a one-cycle strobe.
  always_comb begin
    w_state_next = r_state;
    w_ena        = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_next = S_CHK_A;
      end
      S_CHK_A: begin
        w_addr       = CW'(CSR_CHECK);
        w_state_next = S_CHK_S;
      end
      S_CHK_S: begin
        w_addr       = CW'(CSR_CHECK);
        w_state_next = w_check_ok ? S_W_CLR : S_FIN;
      end
      S_W_CLR: begin
        w_ena        = 1'b1;
        w_addr       = CW'(CSR_END_OF_IN_CONFIG);
        w_state_next = S_W_RADDR;
      end
      S_W_RADDR: begin
        w_ena        = 1'b1;
        w_addr       = CW'(CSR_RD_ADDR);
        w_wdata      = r_raddr;
        w_state_next = S_W_WADDR;
      end
      S_W_WADDR: begin
        w_ena        = 1'b1;
        w_addr       = CW'(CSR_WR_ADDR);
        w_wdata      = r_waddr;
        w_state_next = S_W_IOLEN;
      end
      S_W_IOLEN: begin
        w_ena        = 1'b1;
        w_addr       = CW'(CSR_IO_LEN);
        w_wdata      = DW'(r_iolen);
        w_state_next = S_W_END;
      end
      S_W_END: begin
        w_ena        = 1'b1;
        w_addr       = CW'(CSR_END_OF_IN_CONFIG);
        w_wdata      = DW'(1);
        w_state_next = S_POLL_A;
      end
      S_POLL_A: begin
        w_addr       = CW'(CSR_STATE);
        w_state_next = S_POLL_S;
      end
      S_POLL_S: begin
        w_addr = CW'(CSR_STATE);
        if (w_task_done)         w_state_next = S_TIME_A;
        else if (w_poll_expired) w_state_next = S_FIN;
      end
      S_TIME_A: begin
        w_addr       = CW'(CSR_TIME);
        w_state_next = S_TIME_S;
      end
      S_TIME_S: begin
        w_addr       = CW'(CSR_TIME);
        w_state_next = S_FIN;
      end
      S_FIN: begin
        w_busy       = 1'b0;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_iolen     <= '0;
      r_poll_cnt  <= '0;
      r_err       <= '0;
      r_time_cost <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_raddr <= cfg_raddr;
            r_waddr <= cfg_waddr;
            r_iolen <= cfg_iolen;
            r_err   <= '0;
          end
        end
        S_CHK_S: begin
          if (!w_check_ok) r_err[0] <= 1'b1;
        end
        S_POLL_A: begin
          r_poll_cnt <= '0;
        end
        S_POLL_S: begin
          if (!w_task_done) begin
            if (w_poll_expired) r_err[1]  <= 1'b1;
            else                r_poll_cnt <= r_poll_cnt + 1'b1;
          end
        end
        S_TIME_S: begin
          r_time_cost <= cfg_bus.config_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_bus.config_ena   = w_ena;
  assign cfg_bus.config_addr  = w_addr;
  assign cfg_bus.config_wdata = w_wdata;
  assign busy                 = w_busy;
  assign done                 = w_done;
  assign err                  = r_err;
  assign time_cost            = r_time_cost;

endmodule

// File: tb/tb_sys_config_master.sv
// Directed bench: two initiators (default and short poll limit) each paired with a
// behavioural sys_config slave model; scenarios are hand-timed against the job schedule.
module tb_sys_config_master;

  logic clk = 1'b0;
  logic rst;
  logic s_rst;
  always #5 clk = ~clk;

  logic        in_start [2];
  logic [31:0] in_raddr [2];
  logic [31:0] in_waddr [2];
  logic [11:0] in_iolen [2];

  wire         m_ena   [2];
  wire  [5:0]  m_addr  [2];
  wire  [31:0] m_wdata [2];
  wire         m_busy  [2];
  wire         m_done  [2];
  wire  [1:0]  m_err   [2];
  wire  [31:0] m_time  [2];
  logic [31:0] s_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sys_config_master_if #(.CW(6), .DW(32)) bus ();
    sys_config_master #(
      .AW(12), .DW(32), .CW(6), .TW(24),
      .POLL_LIMIT((gi == 0) ? 24'hFF_FFFF : 24'd16)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (in_start[gi]),
      .cfg_raddr (in_raddr[gi]),
      .cfg_waddr (in_waddr[gi]),
      .cfg_iolen (in_iolen[gi]),
      .cfg_bus   (bus),
      .busy      (m_busy[gi]),
      .done      (m_done[gi]),
      .err       (m_err[gi]),
      .time_cost (m_time[gi])
    );
    assign m_ena[gi]         = bus.config_ena;
    assign m_addr[gi]        = bus.config_addr;
    assign m_wdata[gi]       = bus.config_wdata;
    assign bus.config_rdata  = s_rdata[gi];
  end

  // Slave model: task_done rises delay cycles after the config_done pulse (0 = never).
  logic [31:0] s_raddr [2];
  logic [31:0] s_waddr [2];
  logic [31:0] s_iolen [2];
  logic        s_eoc   [2];
  logic        s_tdone [2];
  logic        s_under [2];
  logic [31:0] s_tcount[2];
  int          s_dcnt  [2];
  int          cd_count[2];
  int          delay   [2];
  bit          bad_link[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_rst) begin
        s_raddr[i] <= 0; s_waddr[i] <= 0; s_iolen[i] <= 0; s_eoc[i] <= 0;
        s_tdone[i] <= 0; s_under[i] <= 0; s_tcount[i] <= 0; s_dcnt[i] <= 0;
        cd_count[i] <= 0; s_rdata[i] <= 0;
      end else begin
        if (s_under[i]) begin
          s_tcount[i] <= s_tcount[i] + 1;
          s_dcnt[i]   <= s_dcnt[i] + 1;
          if (delay[i] > 0 && s_dcnt[i] + 1 == delay[i]) begin
            s_tdone[i] <= 1'b1;
            s_under[i] <= 1'b0;
          end
        end
        if (m_ena[i]) begin
          case (m_addr[i])
            6'h00: s_raddr[i] <= m_wdata[i];
            6'h01: s_waddr[i] <= m_wdata[i];
            6'h02: s_iolen[i] <= m_wdata[i];
            6'h20: begin
              if (m_wdata[i][0] && !s_eoc[i]) begin
                cd_count[i] <= cd_count[i] + 1;
                s_under[i]  <= 1'b1;
                s_tdone[i]  <= 1'b0;
                s_tcount[i] <= 0;
                s_dcnt[i]   <= 0;
              end
              s_eoc[i] <= m_wdata[i][0];
            end
            default: ;
          endcase
        end
        case (m_addr[i])
          6'h00:   s_rdata[i] <= s_raddr[i];
          6'h01:   s_rdata[i] <= s_waddr[i];
          6'h02:   s_rdata[i] <= s_iolen[i];
          6'h20:   s_rdata[i] <= {31'b0, s_eoc[i]};
          6'h21:   s_rdata[i] <= {30'b0, s_under[i], s_tdone[i]};
          6'h22:   s_rdata[i] <= s_tcount[i];
          6'h3F:   s_rdata[i] <= bad_link[i] ? 32'h0 : 32'hF0F0_F0F0;
          default: s_rdata[i] <= 32'h0;
        endcase
      end
    end
  end

  int errors = 0;
  int checks = 0;

  int          j_done;
  int          j_nwr;
  logic [5:0]  wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_cyc  [8];
  logic        busy_tr [64];
  logic        j_rst_busy;
  logic        j_rst_ena;

  // Runs one job on instance g; cycle numbering has start sampled at cycle 0.
  task automatic run_job(input int g, input int extra_start, input int rst_cyc, input int maxc);
    int cyc;
    @(posedge clk); #1;
    in_start[g] = 1'b1;
    cyc = 0; j_done = -1; j_nwr = 0;
    for (int i = 0; i < 64; i++) busy_tr[i] = 1'bx;
    while (cyc < maxc && j_done < 0) begin
      @(posedge clk); #1;
      cyc++;
      in_start[g] = (cyc == extra_start);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        rst = 1'b0;
        j_rst_busy = m_busy[g];
        j_rst_ena  = m_ena[g];
        break;
      end
      if (cyc == rst_cyc) rst = 1'b1;
      if (m_ena[g] && j_nwr < 8) begin
        wr_addr[j_nwr] = m_addr[g];
        wr_data[j_nwr] = m_wdata[g];
        wr_cyc[j_nwr]  = cyc;
        j_nwr++;
      end
      if (cyc < 64) busy_tr[cyc] = m_busy[g];
      if (m_done[g]) j_done = cyc;
    end
    in_start[g] = 1'b0;
    $display("job inst=%0d done_cycle=%0d err=%b time_cost=%0d writes=%0d",
             g, j_done, m_err[g], m_time[g], j_nwr);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++; if (m_busy[g] !== 1'b0)  begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", g, m_busy[g]); end
      checks++; if (m_done[g] !== 1'b0)  begin errors++; $display("FAIL reset_done[%0d] got %b want 0", g, m_done[g]); end
      checks++; if (m_ena[g] !== 1'b0)   begin errors++; $display("FAIL reset_ena[%0d] got %b want 0", g, m_ena[g]); end
      checks++; if (m_addr[g] !== 6'h0)  begin errors++; $display("FAIL reset_addr[%0d] got %h want 00", g, m_addr[g]); end
      checks++; if (m_wdata[g] !== 32'h0) begin errors++; $display("FAIL reset_wdata[%0d] got %h want 0", g, m_wdata[g]); end
      checks++; if (m_err[g] !== 2'b00)  begin errors++; $display("FAIL reset_err[%0d] got %b want 00", g, m_err[g]); end
      checks++; if (m_time[g] !== 32'h0) begin errors++; $display("FAIL reset_time[%0d] got %h want 0", g, m_time[g]); end
    end
    rst = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [5:0]  ea [5];
    logic [31:0] ed [5];
    int cd0;
    ea = '{6'h20, 6'h00, 6'h01, 6'h02, 6'h20};
    ed = '{32'h0, 32'h1000, 32'h2000, 32'h40, 32'h1};
    in_raddr[0] = 32'h1000; in_waddr[0] = 32'h2000; in_iolen[0] = 12'h040;
    delay[0] = 20;
    cd0 = cd_count[0];
    run_job(0, -1, -1, 100);
    checks++; if (j_done != 32) begin errors++; $display("FAIL nom_done_cycle got %0d want 32", j_done); end
    checks++; if (m_err[0] !== 2'b00) begin errors++; $display("FAIL nom_err got %b want 00", m_err[0]); end
    checks++; if (m_time[0] !== 32'd20) begin errors++; $display("FAIL nom_time_cost got %0d want 20", m_time[0]); end
    checks++; if (s_raddr[0] !== 32'h1000) begin errors++; $display("FAIL nom_slave_raddr got %h want 1000", s_raddr[0]); end
    checks++; if (s_waddr[0] !== 32'h2000) begin errors++; $display("FAIL nom_slave_waddr got %h want 2000", s_waddr[0]); end
    checks++; if (s_iolen[0] !== 32'h40) begin errors++; $display("FAIL nom_slave_iolen got %h want 40", s_iolen[0]); end
    checks++; if (cd_count[0] != cd0 + 1) begin errors++; $display("FAIL nom_config_done got %0d want %0d", cd_count[0], cd0 + 1); end
    checks++; if (j_nwr != 5) begin errors++; $display("FAIL nom_write_count got %0d want 5", j_nwr); end
    for (int i = 0; i < 5 && i < j_nwr; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_cyc[i] != i + 3) begin
        errors++;
        $display("FAIL nom_write%0d got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], ea[i], ed[i], i + 3);
      end
    end
    checks++; if (busy_tr[1] !== 1'b1 || busy_tr[31] !== 1'b1 || busy_tr[32] !== 1'b0) begin
      errors++; $display("FAIL nom_busy got c1=%b c31=%b c32=%b want 1 1 0", busy_tr[1], busy_tr[31], busy_tr[32]);
    end
  endtask

  task automatic test_back_to_back();
    int cd0;
    in_raddr[0] = 32'h3000; in_waddr[0] = 32'h3100; in_iolen[0] = 12'h010;
    delay[0] = 5;
    run_job(0, -1, -1, 100);
    // start raised during FIN must be dropped
    in_start[0] = 1'b1;
    @(posedge clk); #1;
    in_start[0] = 1'b0;
    checks++; if (m_busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_start_in_fin busy got %b want 0", m_busy[0]); end
    cd0 = cd_count[0];
    in_raddr[0] = 32'h3300;
    run_job(0, -1, -1, 100);
    checks++; if (cd_count[0] != cd0 + 1) begin errors++; $display("FAIL b2b_config_done got %0d want %0d", cd_count[0], cd0 + 1); end
    checks++; if (j_done != 17) begin errors++; $display("FAIL b2b_done_cycle got %0d want 17", j_done); end
    checks++; if (m_time[0] !== 32'd5) begin errors++; $display("FAIL b2b_time_cost got %0d want 5", m_time[0]); end
    checks++; if (s_raddr[0] !== 32'h3300) begin errors++; $display("FAIL b2b_slave_raddr got %h want 3300", s_raddr[0]); end
  endtask

  task automatic test_bad_link();
    bad_link[0] = 1'b1;
    run_job(0, -1, -1, 40);
    bad_link[0] = 1'b0;
    checks++; if (m_err[0] !== 2'b01) begin errors++; $display("FAIL bad_link_err got %b want 01", m_err[0]); end
    checks++; if (j_done != 3) begin errors++; $display("FAIL bad_link_done_cycle got %0d want 3", j_done); end
    checks++; if (j_nwr != 0) begin errors++; $display("FAIL bad_link_writes got %0d want 0", j_nwr); end
  endtask

  task automatic test_timeout();
    in_raddr[1] = 32'hA0; in_waddr[1] = 32'hB0; in_iolen[1] = 12'h004;
    delay[1] = 0;
    run_job(1, -1, -1, 60);
    checks++; if (m_err[1] !== 2'b10) begin errors++; $display("FAIL timeout_err got %b want 10", m_err[1]); end
    checks++; if (j_done != 26) begin errors++; $display("FAIL timeout_done_cycle got %0d want 26", j_done); end
    checks++; if (j_nwr != 5) begin errors++; $display("FAIL timeout_writes got %0d want 5", j_nwr); end
    checks++; if (m_time[1] !== 32'h0) begin errors++; $display("FAIL timeout_time_cost got %h want 0", m_time[1]); end
  endtask

  task automatic test_start_busy();
    logic [5:0]  ea [5];
    logic [31:0] ed [5];
    ea = '{6'h20, 6'h00, 6'h01, 6'h02, 6'h20};
    ed = '{32'h0, 32'h4000, 32'h5000, 32'h7, 32'h1};
    in_raddr[0] = 32'h4000; in_waddr[0] = 32'h5000; in_iolen[0] = 12'h007;
    delay[0] = 3;
    run_job(0, 5, -1, 100);
    checks++; if (j_done != 15) begin errors++; $display("FAIL busy_start_done_cycle got %0d want 15", j_done); end
    checks++; if (j_nwr != 5) begin errors++; $display("FAIL busy_start_writes got %0d want 5", j_nwr); end
    for (int i = 0; i < 5 && i < j_nwr; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_cyc[i] != i + 3) begin
        errors++;
        $display("FAIL busy_start_write%0d got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wr_addr[i], wr_data[i], wr_cyc[i], ea[i], ed[i], i + 3);
      end
    end
    @(posedge clk); #1;
    checks++; if (m_busy[0] !== 1'b0) begin errors++; $display("FAIL busy_start_idle_after got %b want 0", m_busy[0]); end
  endtask

  task automatic test_reset_mid();
    int cd0;
    in_raddr[0] = 32'h6000; in_waddr[0] = 32'h6100; in_iolen[0] = 12'h020;
    delay[0] = 2;
    run_job(0, -1, 6, 40);
    checks++; if (j_rst_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", j_rst_busy); end
    checks++; if (j_rst_ena !== 1'b0) begin errors++; $display("FAIL rst_mid_ena got %b want 0", j_rst_ena); end
    cd0 = cd_count[0];
    run_job(0, -1, -1, 100);
    checks++; if (j_done != 14) begin errors++; $display("FAIL rst_mid_next_done got %0d want 14", j_done); end
    checks++; if (m_err[0] !== 2'b00) begin errors++; $display("FAIL rst_mid_next_err got %b want 00", m_err[0]); end
    checks++; if (cd_count[0] != cd0 + 1) begin errors++; $display("FAIL rst_mid_config_done got %0d want %0d", cd_count[0], cd0 + 1); end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      in_start[g] = 1'b0; in_raddr[g] = 0; in_waddr[g] = 0; in_iolen[g] = 0;
      delay[g] = 0; bad_link[g] = 1'b0;
    end
    test_reset();
    test_nominal();
    test_back_to_back();
    test_bad_link();
    test_timeout();
    test_start_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
